// File: rtl/frac_strobe_fifo_pkg.sv
// Shared types and constants for the strobe-paced output FIFO.
// Used by frac_strobe_fifo, its interface and its storage sub-module.
package frac_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W = 8;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frac_strobe_fifo_if.sv
// Write port, strobe input and paced output bundle of frac_strobe_fifo.
// master = producer/pacer side, slave = the FIFO.
interface frac_strobe_fifo_if
    import frac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);

    localparam int LW = lvl_w(DEPTH);

    logic              strobe;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              underrun;
    logic [LW-1:0]     level;

    modport master (
        output strobe,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  underrun,
        input  level
    );

    modport slave (
        input  strobe,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        output underrun,
        output level
    );

endinterface

// File: rtl/frac_strobe_fifo_mem.sv
// DEPTH x DATA_W storage with one write port and a registered read port.
// The read register is the FIFO's out_data holding register.
module frac_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/frac_strobe_fifo.sv
// Rate-adapting FIFO released one word per fractional-divider strobe.
// Optional FRAC_STROBE_FIFO_STATS_EN adds underrun_cnt and max_level.
module frac_strobe_fifo
    import frac_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    frac_strobe_fifo_if.slave        bus
`ifdef FRAC_STROBE_FIFO_STATS_EN
    ,
    output logic [CNT_W-1:0]         underrun_cnt,
    output logic [lvl_w(DEPTH)-1:0]  max_level
`endif
);

    localparam int LW = lvl_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);

    state_t        state;
    state_t        state_d;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          wr_en;
    logic          pop;
    logic          und;
    logic          full;
    logic          empty;
    logic          valid_q;
    logic          und_q;

    frac_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (bus.in_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (bus.out_data)
    );

    // Space is judged on the registered level; a same-cycle pop does not help.
    always_comb begin
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);
        wr_en = bus.in_valid && !full;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        und     = 1'b0;
        unique case (state)
            FILL: begin
                if (level_q >= PRE_LVL) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.strobe) begin
                    if (empty) begin
                        und     = 1'b1;
                        state_d = FILL;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state   <= state_d;
            level_q <= level_d;
            valid_q <= pop;
            und_q   <= und;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.level     = level_q;
    assign bus.out_valid = valid_q;
    assign bus.underrun  = und_q;

`ifdef FRAC_STROBE_FIFO_STATS_EN
    // Watermark follows the next level so it moves with the level output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
            max_level    <= '0;
        end else begin
            if (und && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
            if (level_d > max_level) begin
                max_level <= level_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frac_strobe_fifo.sv
// Randomised and directed bench for frac_strobe_fifo against a queue model.
// Define FRAC_STROBE_FIFO_STATS_EN to also check the statistics outputs.
module tb_frac_strobe_fifo;
    import frac_pkg::*;

    localparam int DW      = 8;
    localparam int DEPTH   = 8;
    localparam int PREFILL = 4;
    localparam int LW      = lvl_w(DEPTH);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frac_strobe_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

`ifdef FRAC_STROBE_FIFO_STATS_EN
    logic [CNT_W-1:0] ucnt;
    logic [LW-1:0]    maxl;
`endif

    frac_strobe_fifo #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .PREFILL (PREFILL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave)
`ifdef FRAC_STROBE_FIFO_STATS_EN
        ,
        .underrun_cnt (ucnt),
        .max_level    (maxl)
`endif
    );

    logic [DW-1:0] q[$];
    bit            m_fill;
    logic [DW-1:0] m_data;
    bit            m_valid;
    bit            m_und;
    int            m_ucnt;
    int            m_max;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fill  = 1'b1;
        m_data  = '0;
        m_valid = 1'b0;
        m_und   = 1'b0;
        m_ucnt  = 0;
        m_max   = 0;
    endtask

    task automatic compare();
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("underrun", 32'(bus.underrun), 32'(m_und));
`ifdef FRAC_STROBE_FIFO_STATS_EN
        chk("underrun_cnt", 32'(ucnt), 32'(m_ucnt));
        chk("max_level", 32'(maxl), 32'(m_max));
`endif
    endtask

    // One clock of traffic: model decides from the pre-edge occupancy.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit s);
        int lvl;
        bit wr;
        bit pop;
        bit und;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.strobe   = s;
        lvl = q.size();
        wr  = v && (lvl != DEPTH);
        pop = !m_fill && s && (lvl > 0);
        und = !m_fill && s && (lvl == 0);
        if (m_fill) begin
            if (lvl >= PREFILL) m_fill = 1'b0;
        end else if (und) begin
            m_fill = 1'b1;
        end
        if (pop) m_data = q.pop_front();
        if (wr) q.push_back(d);
        m_valid = pop;
        m_und   = und;
        if (und && m_ucnt < 255) m_ucnt++;
        if (q.size() > m_max) m_max = q.size();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.strobe   = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int win;
        int wp;
        logic [DW-1:0] dn;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.strobe   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare();
        rst = 1'b0;

        // Prefill with 0x11..0x14, then a single release.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("first_pop_valid", 32'(bus.out_valid), 32'd1);
        chk("first_pop_data", 32'(bus.out_data), 32'h11);
        chk("first_pop_level", 32'(bus.level), 32'd3);

        // Strobes while filling are dropped.
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("fill_no_valid", 32'(bus.out_valid), 32'd0);
            chk("fill_no_und", 32'(bus.underrun), 32'd0);
        end
        chk("fill_level", 32'(bus.level), 32'd2);

        // Full buffer: refused write, then pop with a refused write.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 8'hAA, 1'b0);
        chk("full_level", 32'(bus.level), 32'd8);
        step(1'b1, 8'hBB, 1'b1);
        chk("full_pop_level", 32'(bus.level), 32'd7);
        chk("full_pop_data", 32'(bus.out_data), 32'h20);

        // Drain, underrun, then re-prefill.
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_data", 32'(bus.out_data), 32'h27);
        step(1'b0, 8'h00, 1'b1);
        chk("und_pulse", 32'(bus.underrun), 32'd1);
        chk("und_hold_data", 32'(bus.out_data), 32'h27);
        chk("und_no_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("und_one_cycle", 32'(bus.underrun), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b1);
            chk("refill_ignored", 32'(bus.out_valid), 32'd0);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("refill_transition", 32'(bus.level), 32'd4);
        step(1'b0, 8'h00, 1'b1);
        chk("refill_pop", 32'(bus.out_data), 32'h30);

        // Random traffic with varying write pressure and rare resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wp = ((i / 250) % 3 == 0) ? 90 :
                 ((i / 250) % 3 == 1) ? 30 : 10;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < wp,
                     8'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        // Fractional 76/10 pacing with an always-valid producer.
        do_reset();
        acc = 0;
        win = 0;
        dn  = '0;
        for (int c = 0; c < 76 * 12; c++) begin
            bit s;
            s   = (acc + 10 >= 76);
            acc = s ? acc + 10 - 76 : acc + 10;
            step(1'b1, dn, s);
            dn++;
            if (c >= 152) begin
                win += int'(bus.out_valid);
                if ((c - 152) % 76 == 75) begin
                    chk("div_rate", 32'(win), 32'd10);
                    win = 0;
                end
            end
        end
`ifdef FRAC_STROBE_FIFO_STATS_EN
        chk("div_und_cnt", 32'(ucnt), 32'd0);
        chk("div_max_level", 32'(maxl), 32'(DEPTH));
`endif

        // Reset mid-stream at level 5 with a non-zero out_data.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        chk("pre_rst_data", 32'(bus.out_data), 32'h50);
        bus.in_valid = 1'b0;
        bus.strobe   = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
`ifdef FRAC_STROBE_FIFO_STATS_EN
        chk("rst_und_cnt", 32'(ucnt), 32'd0);
        chk("rst_max_level", 32'(maxl), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("post_rst_fill", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
